// File: rtl/lot_gate_arbiter.sv
// lot_gate_arbiter: single-lane barrier controller shared by an entry and an
// exit requester. Round-robin arbitration, open until the matching pass pulse
// or TIMEOUT cycles, then a fixed CLOSE_CYCLES settle before re-arbitrating.
//
// Ports:
//   clk        system clock (CLOCK_50)
//   reset      synchronous active-high reset
//   entry_req  level, car waiting at entry
//   exit_req   level, car waiting at exit
//   full       lot at capacity (blocks entry eligibility)
//   clear      lot empty (blocks exit eligibility)
//   car_in     pulse, entry pass completed
//   car_out    pulse, exit pass completed
//   gate_open  barrier raised
//   grant_in   entry lane owns the gate
//   grant_out  exit lane owns the gate
//   deny       entry request refused while full
//   timeout    pulse, grant ended without a pass
//   dir_err    pulse, pass pulse for the non-granted direction
module lot_gate_arbiter #(
    parameter int unsigned TIMEOUT      = 250_000_000,
    parameter int unsigned CLOSE_CYCLES = 50_000_000,
    parameter int unsigned TW           = 28
) (
    input  logic clk,
    input  logic reset,
    input  logic entry_req,
    input  logic exit_req,
    input  logic full,
    input  logic clear,
    input  logic car_in,
    input  logic car_out,
    output logic gate_open,
    output logic grant_in,
    output logic grant_out,
    output logic deny,
    output logic timeout,
    output logic dir_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSING  = 2'd3
    } state_t;

    // Terminal timer values: the timer starts at 0 on state entry, so the
    // last cycle of a window of N cycles sees N-1.
    localparam logic [TW-1:0] OPEN_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          last_in;      // 1: entry granted last, 0: exit granted last
    logic          last_in_nxt;
    logic          timeout_nxt;
    logic          dir_err_nxt;
    logic          entry_ok;
    logic          exit_ok;

    // Next-state, pointer, timer and pulse decode.
    always_comb begin
        state_nxt   = state;
        last_in_nxt = last_in;
        timeout_nxt = 1'b0;
        dir_err_nxt = 1'b0;
        timer_nxt   = '0;
        entry_ok    = entry_req & ~full;
        exit_ok     = exit_req & ~clear;

        case (state)
            IDLE: begin
                // On a tie the lane not granted last wins.
                if (entry_ok && (!exit_ok || !last_in)) begin
                    state_nxt   = OPEN_IN;
                    last_in_nxt = 1'b1;
                end else if (exit_ok) begin
                    state_nxt   = OPEN_OUT;
                    last_in_nxt = 1'b0;
                end
            end
            OPEN_IN: begin
                dir_err_nxt = car_out;
                // Pass beats expiry on the same edge.
                if (car_in) begin
                    state_nxt = CLOSING;
                end else if (timer == OPEN_LAST) begin
                    state_nxt   = CLOSING;
                    timeout_nxt = 1'b1;
                end
            end
            OPEN_OUT: begin
                dir_err_nxt = car_in;
                if (car_out) begin
                    state_nxt = CLOSING;
                end else if (timer == OPEN_LAST) begin
                    state_nxt   = CLOSING;
                    timeout_nxt = 1'b1;
                end
            end
            CLOSING: begin
                dir_err_nxt = car_in | car_out;
                if (timer == CLOSE_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Timer restarts on every state change and idles at 0.
        if ((state_nxt != state) || (state_nxt == IDLE)) begin
            timer_nxt = '0;
        end else begin
            timer_nxt = timer + TW'(1);
        end
    end

    // State, timer and registered outputs (decoded from the next state so
    // they line up with the state register).
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            last_in   <= 1'b0;
            gate_open <= 1'b0;
            grant_in  <= 1'b0;
            grant_out <= 1'b0;
            deny      <= 1'b0;
            timeout   <= 1'b0;
            dir_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            last_in   <= last_in_nxt;
            gate_open <= (state_nxt == OPEN_IN) || (state_nxt == OPEN_OUT);
            grant_in  <= (state_nxt == OPEN_IN);
            grant_out <= (state_nxt == OPEN_OUT);
            deny      <= entry_req & full;
            timeout   <= timeout_nxt;
            dir_err   <= dir_err_nxt;
        end
    end

endmodule

// File: tb/tb_lot_gate_arbiter.sv
// Testbench for lot_gate_arbiter with TIMEOUT=8, CLOSE_CYCLES=3.
// A countdown-based reference model tracks who owns the gate and how many
// open/closing cycles remain; directed scenarios plus a random run.
module tb_lot_gate_arbiter;

    localparam int unsigned TIMEOUT      = 8;
    localparam int unsigned CLOSE_CYCLES = 3;
    localparam int unsigned TW           = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic entry_req = 1'b0;
    logic exit_req = 1'b0;
    logic full = 1'b0;
    logic clear = 1'b0;
    logic car_in = 1'b0;
    logic car_out = 1'b0;
    logic gate_open, grant_in, grant_out, deny, timeout, dir_err;

    int checks = 0;
    int errors = 0;

    lot_gate_arbiter #(
        .TIMEOUT     (TIMEOUT),
        .CLOSE_CYCLES(CLOSE_CYCLES),
        .TW          (TW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .entry_req(entry_req),
        .exit_req (exit_req),
        .full     (full),
        .clear    (clear),
        .car_in   (car_in),
        .car_out  (car_out),
        .gate_open(gate_open),
        .grant_in (grant_in),
        .grant_out(grant_out),
        .deny     (deny),
        .timeout  (timeout),
        .dir_err  (dir_err)
    );

    always #5 clk = ~clk;

    wire [5:0] dut_vec = {gate_open, grant_in, grant_out, deny, timeout, dir_err};

    // Reference model: owner 0=none, 1=entry, 2=exit; countdowns of cycles left.
    int       m_owner = 0;
    int       m_open_left = 0;
    int       m_close_left = 0;
    bit       m_last_in = 1'b0;
    bit       m_deny = 1'b0;
    bit       m_timeout = 1'b0;
    bit       m_dir_err = 1'b0;
    logic [5:0] m_vec = 6'b0;

    task automatic model_step();
        bit pass, wrong, ein, xout;
        m_timeout = 1'b0;
        m_dir_err = 1'b0;
        if (reset) begin
            m_owner = 0; m_open_left = 0; m_close_left = 0;
            m_last_in = 1'b0; m_deny = 1'b0;
        end else begin
            m_deny = entry_req & full;
            if (m_owner != 0) begin
                pass  = (m_owner == 1) ? car_in  : car_out;
                wrong = (m_owner == 1) ? car_out : car_in;
                m_dir_err = wrong;
                if (pass) begin
                    m_owner = 0;
                    m_close_left = CLOSE_CYCLES;
                end else begin
                    m_open_left--;
                    if (m_open_left == 0) begin
                        m_timeout = 1'b1;
                        m_owner = 0;
                        m_close_left = CLOSE_CYCLES;
                    end
                end
            end else if (m_close_left > 0) begin
                m_dir_err = car_in | car_out;
                m_close_left--;
            end else begin
                ein  = entry_req & ~full;
                xout = exit_req & ~clear;
                if (ein && xout) m_owner = m_last_in ? 2 : 1;
                else if (ein)    m_owner = 1;
                else if (xout)   m_owner = 2;
                if (m_owner != 0) begin
                    m_last_in = (m_owner == 1);
                    m_open_left = TIMEOUT;
                end
            end
        end
        m_vec = {m_owner != 0, m_owner == 1, m_owner == 2, m_deny, m_timeout, m_dir_err};
    endtask

    // One clock: model follows the same sampled inputs, outputs read at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        entry_req = 1'b0; exit_req = 1'b0; full = 1'b0; clear = 1'b0;
        car_in = 1'b0; car_out = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (dut_vec !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 000000", dut_vec);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (dut_vec !== m_vec) begin
            errors++;
            $display("FAIL reset_idle got %b expected %b", dut_vec, m_vec);
        end
    endtask

    task automatic test_basic_entry();
        int low;
        do_reset();
        entry_req = 1'b1;
        tick();
        checks++;
        if (!(gate_open === 1'b1 && grant_in === 1'b1 && grant_out === 1'b0)) begin
            errors++;
            $display("FAIL basic_grant got %b expected gate+grant_in", dut_vec);
        end
        tick();
        tick();
        car_in = 1'b1;
        tick();
        car_in = 1'b0;
        checks++;
        if (gate_open !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL basic_pass_close got gate=%b timeout=%b expected 0 0", gate_open, timeout);
        end
        low = 1;
        while (gate_open !== 1'b1 && low < 20) begin
            tick();
            checks++;
            if (dut_vec !== m_vec) begin
                errors++;
                $display("FAIL basic_model got %b expected %b", dut_vec, m_vec);
            end
            if (gate_open !== 1'b1) low++;
        end
        checks++;
        if (low != CLOSE_CYCLES + 1 || grant_in !== 1'b1) begin
            errors++;
            $display("FAIL basic_regrant_gap got %0d cycles grant_in=%b expected %0d 1",
                     low, grant_in, CLOSE_CYCLES + 1);
        end
        entry_req = 1'b0;
        car_in = 1'b1;
        tick();
        car_in = 1'b0;
    endtask

    task automatic test_alternate();
        int n;
        do_reset();
        entry_req = 1'b1;
        exit_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (gate_open !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (gate_open !== 1'b1 || grant_in !== ((g % 2) == 0) || grant_out !== ((g % 2) == 1)) begin
                errors++;
                $display("FAIL alternate_grant%0d got in=%b out=%b expected in=%0d", g,
                         grant_in, grant_out, (g % 2) == 0);
            end
            repeat ($urandom_range(0, 4)) tick();
            if (grant_in === 1'b1) car_in = 1'b1;
            else car_out = 1'b1;
            tick();
            car_in = 1'b0;
            car_out = 1'b0;
            checks++;
            if (dut_vec !== m_vec || gate_open !== 1'b0) begin
                errors++;
                $display("FAIL alternate_pass%0d got %b expected %b", g, dut_vec, m_vec);
            end
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int hi, low;
        do_reset();
        exit_req = 1'b1;
        tick();
        hi = 0;
        while (gate_open === 1'b1 && hi < 30) begin
            hi++;
            tick();
        end
        checks++;
        if (hi != TIMEOUT || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_window got %0d cycles timeout=%b expected %0d 1", hi, timeout, TIMEOUT);
        end
        low = 1;
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width got %b expected 0", timeout);
        end
        while (gate_open !== 1'b1 && low < 30) begin
            low++;
            tick();
        end
        checks++;
        if (low != CLOSE_CYCLES + 1 || grant_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout_regrant got gap %0d grant_out=%b expected %0d 1",
                     low, grant_out, CLOSE_CYCLES + 1);
        end
        exit_req = 1'b0;
        car_out = 1'b1;
        tick();
        car_out = 1'b0;
    endtask

    task automatic test_full_clear();
        do_reset();
        entry_req = 1'b1;
        full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (deny !== 1'b1 || grant_in !== 1'b0) begin
                errors++;
                $display("FAIL full_deny got deny=%b grant_in=%b expected 1 0", deny, grant_in);
            end
        end
        full = 1'b0;
        tick();
        checks++;
        if (grant_in !== 1'b1 || deny !== 1'b0) begin
            errors++;
            $display("FAIL full_release got grant_in=%b deny=%b expected 1 0", grant_in, deny);
        end
        entry_req = 1'b0;
        car_in = 1'b1;
        tick();
        car_in = 1'b0;
        do_reset();
        exit_req = 1'b1;
        clear = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (gate_open !== 1'b0 || grant_out !== 1'b0) begin
                errors++;
                $display("FAIL clear_block got gate=%b grant_out=%b expected 0 0", gate_open, grant_out);
            end
        end
        idle_inputs();
    endtask

    task automatic test_dir_err();
        do_reset();
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        car_out = 1'b1;
        tick();
        car_out = 1'b0;
        checks++;
        if (dir_err !== 1'b1 || gate_open !== 1'b1) begin
            errors++;
            $display("FAIL dir_err_pulse got dir_err=%b gate=%b expected 1 1", dir_err, gate_open);
        end
        tick();
        checks++;
        if (dir_err !== 1'b0) begin
            errors++;
            $display("FAIL dir_err_width got %b expected 0", dir_err);
        end
        repeat (TIMEOUT - 3) tick();
        checks++;
        if (gate_open !== 1'b1) begin
            errors++;
            $display("FAIL dir_err_still_open got %b expected 1", gate_open);
        end
        car_in = 1'b1;
        tick();
        car_in = 1'b0;
        checks++;
        if (gate_open !== 1'b0 || timeout !== 1'b0 || dut_vec !== m_vec) begin
            errors++;
            $display("FAIL pass_at_expiry got gate=%b timeout=%b expected 0 0", gate_open, timeout);
        end
        car_out = 1'b1;
        tick();
        car_out = 1'b0;
        checks++;
        if (dir_err !== 1'b1) begin
            errors++;
            $display("FAIL closing_dir_err got %b expected 1", dir_err);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        exit_req = 1'b1;
        n = 0;
        while (grant_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        tick();
        reset = 1'b1;
        car_out = 1'b1;
        tick();
        reset = 1'b0;
        car_out = 1'b0;
        checks++;
        if (dut_vec !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid got %b expected 000000", dut_vec);
        end
        entry_req = 1'b1;
        exit_req = 1'b1;
        tick();
        checks++;
        if (grant_in !== 1'b1 || grant_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_first got in=%b out=%b expected 1 0", grant_in, grant_out);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            entry_req = ($urandom_range(0, 9) < 7);
            exit_req  = ($urandom_range(0, 9) < 7);
            full      = ($urandom_range(0, 9) < 2);
            clear     = ($urandom_range(0, 9) < 2);
            car_in    = ($urandom_range(0, 99) < 15);
            car_out   = ($urandom_range(0, 99) < 15);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (dut_vec !== m_vec) begin
                errors++;
                $display("FAIL random_cycle%0d got %b expected %b", i, dut_vec, m_vec);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_entry();
        test_alternate();
        test_timeout();
        test_full_clear();
        test_dir_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
